// File: rtl/alu_dispatch_pkg.sv
// Shared types and default constants for the ALU function dispatcher.
package alu_dispatch_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'b00,
    ST_BUSY  = 2'b01,
    ST_DONE  = 2'b10,
    ST_ABORT = 2'b11
  } state_t;

  localparam int DEF_SEL_W       = 2;
  localparam int DEF_NUM_UNITS   = 4;
  localparam int DEF_TIMEOUT_CYC = 16;

endpackage

// File: rtl/alu_dispatch_fun_onehot_dec.sv
// Code-to-one-hot decoder with enable; flags codes that address no existing unit.
module fun_onehot_dec
  import alu_dispatch_pkg::*;
#(
  parameter int SEL_W     = DEF_SEL_W,
  parameter int NUM_UNITS = DEF_NUM_UNITS
) (
  input  logic [SEL_W-1:0]     code,
  input  logic                 en,
  output logic [NUM_UNITS-1:0] onehot,
  output logic                 legal
);

  always_comb begin
    onehot = '0;
    legal  = (int'(code) < NUM_UNITS);
    for (int i = 0; i < NUM_UNITS; i++) begin
      if (en && (int'(code) == i)) begin
        onehot[i] = 1'b1;
      end
    end
  end

endmodule

// File: rtl/alu_dispatch.sv
// Registered ALU function dispatcher: valid/ready request in, one-hot unit enable held until done.
// Optional BUSY watchdog enabled by defining ALU_DISPATCH_TIMEOUT_EN.
module alu_dispatch
  import alu_dispatch_pkg::*;
#(
  parameter int SEL_W       = DEF_SEL_W,
  parameter int NUM_UNITS   = DEF_NUM_UNITS,
  parameter int TIMEOUT_CYC = DEF_TIMEOUT_CYC
) (
  input  logic                 CLK,
  input  logic                 RST,
  input  logic [SEL_W-1:0]     ALU_FUN,
  input  logic                 Req_Valid,
  output logic                 Req_Ready,
  output logic [NUM_UNITS-1:0] Unit_Enable,
  input  logic [NUM_UNITS-1:0] Unit_Done,
  output logic                 Op_Done,
  output logic                 Illegal_Op,
  output logic                 Timeout,
  output logic                 Busy
);

  if (NUM_UNITS < 1 || NUM_UNITS > 2**SEL_W || TIMEOUT_CYC < 1) begin : g_bad_params
    $error("alu_dispatch: illegal parameter combination");
  end

  state_t               state;
  logic [SEL_W-1:0]     sel_q;
  logic                 illegal_q;
  logic [NUM_UNITS-1:0] dec_onehot;
  logic                 dec_legal;
  logic                 fun_legal;
  logic                 sel_done;
  logic                 limit_hit;

  // Only the latched code drives the enables, so later ALU_FUN changes are invisible.
  fun_onehot_dec #(
    .SEL_W     (SEL_W),
    .NUM_UNITS (NUM_UNITS)
  ) u_dec (
    .code   (sel_q),
    .en     (state == ST_BUSY),
    .onehot (dec_onehot),
    .legal  (dec_legal)
  );

  assign fun_legal = (int'(ALU_FUN) < NUM_UNITS);
  assign sel_done  = |(Unit_Done & dec_onehot);

`ifdef ALU_DISPATCH_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT_CYC + 1);
  logic [CNT_W-1:0] wait_cnt;
  assign limit_hit = (wait_cnt == CNT_W'(TIMEOUT_CYC - 1));
`else
  assign limit_hit = 1'b0;
`endif

  // Done is tested before the limit so a coincident completion is never aborted.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state     <= ST_IDLE;
      sel_q     <= '0;
      illegal_q <= 1'b0;
`ifdef ALU_DISPATCH_TIMEOUT_EN
      wait_cnt  <= '0;
`endif
    end else begin
      illegal_q <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (Req_Valid) begin
            if (fun_legal) begin
              sel_q <= ALU_FUN;
              state <= ST_BUSY;
`ifdef ALU_DISPATCH_TIMEOUT_EN
              wait_cnt <= '0;
`endif
            end else begin
              illegal_q <= 1'b1;
            end
          end
        end
        ST_BUSY: begin
          if (sel_done) begin
            state <= ST_DONE;
          end else if (limit_hit) begin
            state <= ST_ABORT;
          end else begin
`ifdef ALU_DISPATCH_TIMEOUT_EN
            wait_cnt <= wait_cnt + 1'b1;
`endif
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  assign Req_Ready   = (state == ST_IDLE);
  assign Busy        = (state != ST_IDLE);
  assign Op_Done     = (state == ST_DONE);
  assign Illegal_Op  = illegal_q;
  assign Unit_Enable = dec_onehot & {NUM_UNITS{dec_legal}};
`ifdef ALU_DISPATCH_TIMEOUT_EN
  assign Timeout     = (state == ST_ABORT);
`else
  assign Timeout     = 1'b0;
`endif

endmodule

// File: tb/tb_alu_dispatch.sv
// Self-checking bench for alu_dispatch: a 4-unit and a 3-unit instance share one stimulus stream.
module tb_alu_dispatch;

  localparam int TO_CYC = 4;
`ifdef ALU_DISPATCH_TIMEOUT_EN
  localparam bit TO_EN = 1'b1;
`else
  localparam bit TO_EN = 1'b0;
`endif

  logic       CLK = 1'b0;
  logic       RST;
  logic [1:0] ALU_FUN;
  logic       Req_Valid;
  logic [3:0] Unit_Done;

  logic       ready4, op_done4, illegal4, timeout4, busy4;
  logic [3:0] en4;
  logic       ready3, op_done3, illegal3, timeout3, busy3;
  logic [2:0] en3;

  int checks = 0;
  int errors = 0;
  bit cmp_en = 1'b0;

  always #5 CLK = ~CLK;

  alu_dispatch #(.SEL_W(2), .NUM_UNITS(4), .TIMEOUT_CYC(TO_CYC)) dut4 (
    .CLK(CLK), .RST(RST), .ALU_FUN(ALU_FUN), .Req_Valid(Req_Valid),
    .Req_Ready(ready4), .Unit_Enable(en4), .Unit_Done(Unit_Done),
    .Op_Done(op_done4), .Illegal_Op(illegal4), .Timeout(timeout4), .Busy(busy4)
  );

  alu_dispatch #(.SEL_W(2), .NUM_UNITS(3), .TIMEOUT_CYC(TO_CYC)) dut3 (
    .CLK(CLK), .RST(RST), .ALU_FUN(ALU_FUN), .Req_Valid(Req_Valid),
    .Req_Ready(ready3), .Unit_Enable(en3), .Unit_Done(Unit_Done[2:0]),
    .Op_Done(op_done3), .Illegal_Op(illegal3), .Timeout(timeout3), .Busy(busy3)
  );

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: which unit owns an op, how long it has waited, and pending pulses.
  bit m_active[2], m_done[2], m_abort[2], m_illegal[2];
  int m_sel[2], m_wait[2];

  always @(posedge CLK or posedge RST) begin
    if (RST) begin
      for (int i = 0; i < 2; i++) begin
        m_active[i] = 0; m_done[i] = 0; m_abort[i] = 0; m_illegal[i] = 0;
        m_sel[i] = 0; m_wait[i] = 0;
      end
    end else begin
      for (int i = 0; i < 2; i++) begin
        int nu;
        bit finishing;
        nu = (i == 0) ? 4 : 3;
        finishing = m_done[i] | m_abort[i];
        m_done[i] = 0; m_abort[i] = 0; m_illegal[i] = 0;
        if (m_active[i]) begin
          if (Unit_Done[m_sel[i]]) begin
            m_active[i] = 0; m_done[i] = 1;
          end else if (TO_EN && (m_wait[i] + 1 >= TO_CYC)) begin
            m_active[i] = 0; m_abort[i] = 1;
          end else begin
            m_wait[i]++;
          end
        end else if (!finishing && Req_Valid) begin
          if (int'(ALU_FUN) < nu) begin
            m_active[i] = 1; m_sel[i] = int'(ALU_FUN); m_wait[i] = 0;
          end else begin
            m_illegal[i] = 1;
          end
        end
      end
    end
  end

  task automatic compareOne(input int i, input string tag, input logic rdy, input logic [3:0] en,
                            input logic od, input logic il, input logic to, input logic bsy);
    logic [3:0] exp_en;
    logic       exp_rdy;
    exp_en  = m_active[i] ? (4'b0001 << m_sel[i]) : 4'b0000;
    exp_rdy = !(m_active[i] || m_done[i] || m_abort[i]);
    checkOutput({tag, ".Req_Ready"},   32'(rdy), 32'(exp_rdy));
    checkOutput({tag, ".Unit_Enable"}, 32'(en),  32'(exp_en));
    checkOutput({tag, ".Op_Done"},     32'(od),  32'(m_done[i]));
    checkOutput({tag, ".Illegal_Op"},  32'(il),  32'(m_illegal[i]));
    checkOutput({tag, ".Timeout"},     32'(to),  32'(m_abort[i]));
    checkOutput({tag, ".Busy"},        32'(bsy), 32'(!exp_rdy));
  endtask

  always @(negedge CLK) begin
    if (cmp_en) begin
      compareOne(0, "model4", ready4, en4, op_done4, illegal4, timeout4, busy4);
      compareOne(1, "model3", ready3, {1'b0, en3}, op_done3, illegal3, timeout3, busy3);
    end
  end

  task automatic applyStimulus(input logic v, input logic [1:0] f, input logic [3:0] d);
    Req_Valid = v;
    ALU_FUN   = f;
    Unit_Done = d;
    @(posedge CLK);
    #1;
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not complete in time");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int pulses;
    RST = 1'b1; Req_Valid = 1'b0; ALU_FUN = 2'd0; Unit_Done = 4'b0000;
    repeat (2) @(posedge CLK);
    #1;
    checkOutput("reset.Req_Ready", 32'(ready4), 32'd1);
    checkOutput("reset.Busy", 32'(busy4), 32'd0);
    checkOutput("reset.Unit_Enable", 32'(en4), 32'd0);
    checkOutput("reset.Op_Done", 32'(op_done4), 32'd0);
    checkOutput("reset.Illegal_Op", 32'(illegal4), 32'd0);
    checkOutput("reset.Timeout", 32'(timeout4), 32'd0);
    RST = 1'b0;
    cmp_en = 1'b1;

    // Unit 2 completes three cycles after acceptance; ALU_FUN changes are ignored.
    applyStimulus(1'b1, 2'd2, 4'b0000);
    checkOutput("op2.enable_c0", 32'(en4), 32'h4);
    checkOutput("op2.ready_low", 32'(ready4), 32'd0);
    applyStimulus(1'b0, 2'd2, 4'b0000);
    checkOutput("op2.enable_c1", 32'(en4), 32'h4);
    applyStimulus(1'b0, 2'd0, 4'b0000);
    checkOutput("op2.enable_c2", 32'(en4), 32'h4);
    applyStimulus(1'b0, 2'd0, 4'b0100);
    checkOutput("op2.op_done", 32'(op_done4), 32'd1);
    checkOutput("op2.enable_off", 32'(en4), 32'h0);
    checkOutput("op2.ready_in_done", 32'(ready4), 32'd0);
    applyStimulus(1'b0, 2'd0, 4'b0000);
    checkOutput("op2.op_done_end", 32'(op_done4), 32'd0);
    checkOutput("op2.ready_back", 32'(ready4), 32'd1);

    // Done flags of unselected units must not complete a unit-0 op.
    applyStimulus(1'b1, 2'd0, 4'b0000);
    for (int i = 0; i < 3; i++) begin
      applyStimulus(1'b0, 2'd0, 4'b1110);
      checkOutput("op0.still_busy", 32'(busy4), 32'd1);
      checkOutput("op0.no_op_done", 32'(op_done4), 32'd0);
      checkOutput("op0.enable", 32'(en4), 32'h1);
    end
    applyStimulus(1'b0, 2'd0, 4'b0001);
    checkOutput("op0.op_done", 32'(op_done4), 32'd1);
    applyStimulus(1'b0, 2'd0, 4'b0000);

    // Code 3: illegal on the 3-unit instance, legal unit 3 on the 4-unit one.
    applyStimulus(1'b1, 2'd3, 4'b0000);
    checkOutput("illegal3.pulse", 32'(illegal3), 32'd1);
    checkOutput("illegal3.enable", 32'(en3), 32'h0);
    checkOutput("illegal3.ready", 32'(ready3), 32'd1);
    checkOutput("legal4.enable", 32'(en4), 32'h8);
    checkOutput("legal4.no_illegal", 32'(illegal4), 32'd0);
    applyStimulus(1'b1, 2'd1, 4'b0000);
    checkOutput("illegal3.next_accept", 32'(en3), 32'h2);
    checkOutput("illegal3.pulse_end", 32'(illegal3), 32'd0);
    checkOutput("legal4.ignores_req", 32'(en4), 32'h8);
    applyStimulus(1'b0, 2'd0, 4'b1010);
    checkOutput("mixed.op_done4", 32'(op_done4), 32'd1);
    checkOutput("mixed.op_done3", 32'(op_done3), 32'd1);
    applyStimulus(1'b0, 2'd0, 4'b0000);

    // Asynchronous reset between edges drops the in-flight op.
    applyStimulus(1'b1, 2'd1, 4'b0000);
    applyStimulus(1'b0, 2'd1, 4'b0000);
    #2;
    RST = 1'b1;
    #1;
    checkOutput("async_rst.enable4", 32'(en4), 32'h0);
    checkOutput("async_rst.busy4", 32'(busy4), 32'd0);
    checkOutput("async_rst.enable3", 32'(en3), 32'h0);
    checkOutput("async_rst.busy3", 32'(busy3), 32'd0);
    #3;
    RST = 1'b0;
    for (int i = 0; i < 2; i++) begin
      applyStimulus(1'b0, 2'd1, 4'b1111);
      checkOutput("async_rst.no_op_done", 32'(op_done4), 32'd0);
      checkOutput("async_rst.ready", 32'(ready4), 32'd1);
    end

`ifdef ALU_DISPATCH_TIMEOUT_EN
    // No done: abort after TO_CYC busy cycles.
    applyStimulus(1'b1, 2'd1, 4'b0000);
    for (int i = 0; i < TO_CYC - 1; i++) begin
      applyStimulus(1'b0, 2'd1, 4'b0000);
      checkOutput("timeout.waiting", 32'(timeout4), 32'd0);
      checkOutput("timeout.enable", 32'(en4), 32'h2);
    end
    applyStimulus(1'b0, 2'd1, 4'b0000);
    checkOutput("timeout.pulse", 32'(timeout4), 32'd1);
    checkOutput("timeout.enable_off", 32'(en4), 32'h0);
    checkOutput("timeout.no_op_done", 32'(op_done4), 32'd0);
    applyStimulus(1'b0, 2'd1, 4'b0000);
    checkOutput("timeout.ready", 32'(ready4), 32'd1);
    checkOutput("timeout.pulse_end", 32'(timeout4), 32'd0);
    // Done arrives on the limit edge and wins.
    applyStimulus(1'b1, 2'd1, 4'b0000);
    for (int i = 0; i < TO_CYC - 1; i++) applyStimulus(1'b0, 2'd1, 4'b0000);
    applyStimulus(1'b0, 2'd1, 4'b0010);
    checkOutput("tie.op_done", 32'(op_done4), 32'd1);
    checkOutput("tie.timeout", 32'(timeout4), 32'd0);
    applyStimulus(1'b0, 2'd1, 4'b0000);
`else
    // Without the watchdog a unit may take arbitrarily long.
    applyStimulus(1'b1, 2'd1, 4'b0000);
    for (int i = 0; i < 2 * TO_CYC; i++) begin
      applyStimulus(1'b0, 2'd1, 4'b0000);
      checkOutput("no_timeout.busy", 32'(busy4), 32'd1);
      checkOutput("no_timeout.timeout", 32'(timeout4), 32'd0);
    end
    applyStimulus(1'b0, 2'd1, 4'b0010);
    checkOutput("no_timeout.op_done", 32'(op_done4), 32'd1);
    applyStimulus(1'b0, 2'd1, 4'b0000);
`endif

    // Zero-latency units with a request always pending: one op per three cycles.
    pulses = 0;
    for (int i = 0; i < 9; i++) begin
      applyStimulus(1'b1, 2'(i % 4), 4'b1111);
      if (op_done4 === 1'b1) pulses++;
    end
    checkOutput("throughput.op_done_count", 32'(pulses), 32'd3);
    applyStimulus(1'b0, 2'd0, 4'b0000);
    applyStimulus(1'b0, 2'd0, 4'b0000);

    cmp_en = 1'b0;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/alu_dispatch.md
# alu_dispatch

Parametrised, registered ALU function dispatcher: decodes an `ALU_FUN` code into a one-hot enable for one of `NUM_UNITS` execution units (arithmetic, logic, compare, shift, …). It accepts requests over a valid/ready handshake and holds the selected enable until that unit signals completion. It sits between the ALU top-level control and the unit array, and replaces purely combinational enable decoding where units take more than one cycle.

## Interface
- `SEL_W`, default 2: width of `ALU_FUN`.
- `NUM_UNITS`, default 4: number of units; legal range 1..2**`SEL_W`.
- `TIMEOUT_CYC`, default 16: cycles to wait for `Unit_Done` before aborting; only used with `ALU_DISPATCH_TIMEOUT_EN`; minimum 1.

- `CLK` in 1: single clock; all state changes on the rising edge.
- `RST` in 1: asynchronous, active-high reset.
- `ALU_FUN` in `SEL_W`: function/unit select; sampled on acceptance.
- `Req_Valid` in 1: request present.
- `Req_Ready` out 1: dispatcher can accept a request.
- `Unit_Enable` out `NUM_UNITS`: one-hot (or zero) enable to the units.
- `Unit_Done` in `NUM_UNITS`: per-unit completion flags.
- `Op_Done` out 1: one-cycle pulse when the dispatched op completes.
- `Illegal_Op` out 1: one-cycle pulse when a request with `ALU_FUN` ≥ `NUM_UNITS` is accepted.
- `Timeout` out 1: one-cycle abort pulse; tied 0 without the macro.
- `Busy` out 1: high whenever the state is not IDLE.

## Operation
- FSM states:
  - IDLE: `Req_Ready`=1, `Unit_Enable`=0.
  - BUSY: `Unit_Enable`=onehot(latched code).
  - DONE: `Op_Done`=1.
  - ABORT: `Timeout`=1.
- Acceptance: `Req_Valid` & `Req_Ready` at an edge.
  - Legal code: latch it, go to BUSY.
  - Illegal code: stay in IDLE, pulse `Illegal_Op` for the next cycle; no enable is asserted.
- BUSY: `Unit_Done[sel]` sampled high → DONE. `Unit_Done` bits of unselected units are ignored.
- DONE → IDLE unconditionally. ABORT → IDLE unconditionally.
- `ALU_FUN` changes after acceptance have no effect until the next acceptance.
- `Unit_Enable` is never multi-hot. It is all-zero outside BUSY.
- Reset mid-operation: FSM returns to IDLE immediately (asynchronous). `Unit_Enable`, `Op_Done`, `Illegal_Op` and `Timeout` go to 0. The in-flight op is dropped and no `Op_Done` is issued.
- Reset values:
  - `Req_Ready`=1.
  - `Busy`=0.
  - All other outputs 0.
  - Latched code 0. Timeout counter 0.

## Timing
- Request accepted at edge k:
  - `Unit_Enable` high from edge k through the edge where done is sampled.
  - `Req_Ready` low from edge k.
- Unit done with zero latency (`Unit_Done[sel]` high at edge k+1): enable lasts exactly 1 cycle. `Op_Done` is high in cycle k+1..k+2. `Req_Ready` is high again after edge k+2.
- Maximum throughput is one op per 3 cycles.
- `Illegal_Op` is high in the cycle after the accepting edge. `Req_Ready` stays high, so back-to-back requests are allowed.
- All outputs are registered or decoded from the state register only. There is no combinational path from inputs to outputs.

## Configuration
- Macro: `ALU_DISPATCH_TIMEOUT_EN`.
- Defined:
  - A counter clears on entry to BUSY and increments each BUSY cycle.
  - If it reaches `TIMEOUT_CYC` with no done sampled → ABORT: `Timeout` pulses 1 cycle, enable drops, no `Op_Done`.
  - If done and the limit coincide on the same edge, done wins.
- Not defined: no counter; BUSY waits indefinitely; `Timeout` is constant 0; the ABORT state is unreachable.

## Structure
- Package `alu_dispatch_pkg`:
  - FSM state type/encodings: IDLE=2'b00, BUSY=2'b01, DONE=2'b10, ABORT=2'b11.
  - Default parameter constants.
- Sub-module `fun_onehot_dec`:
  - Parametrised (`SEL_W`, `NUM_UNITS`) combinational code-to-one-hot decoder with an enable input.
  - Also outputs a `legal` flag.
  - Instantiated once: on the latched code, gated by BUSY.

## Test plan
- Reset, then `ALU_FUN`=2, `Req_Valid`=1 for one cycle; `Unit_Done[2]` 3 cycles later → `Unit_Enable`=4'b0100 for 3 cycles, then one `Op_Done` pulse, then `Req_Ready`=1.
- BUSY on unit 0 with `Unit_Done`=4'b1110 held high → stays BUSY, no `Op_Done`; then `Unit_Done[0]` → completes normally.
- `NUM_UNITS`=3, `ALU_FUN`=3 → `Illegal_Op` pulse, `Unit_Enable`=0, `Req_Ready` stays 1; the next request with code 1 is accepted on the following edge.
- `RST` asserted mid-BUSY, asynchronously between edges → `Unit_Enable`=0 and `Busy`=0 immediately; no `Op_Done` after release.
- With `ALU_DISPATCH_TIMEOUT_EN`, `TIMEOUT_CYC`=4, no done → `Timeout` pulse after 4 BUSY cycles, enable drops, `Req_Ready`=1 next cycle.
- Same setup with done and the limit on the same edge → `Op_Done`=1, `Timeout`=0.
